// File: rtl/op_loader_pkg.sv
// Shared constants for the opcode stream loader: opcode values, command codes,
// in_data field positions and the loader state encoding.
package op_loader_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDP = 3'd1;
    localparam logic [2:0] OP_MAC  = 3'd2;
    localparam logic [2:0] OP_POPC = 3'd4;
    localparam logic [2:0] OP_REV  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    localparam logic [2:0] CMD_RUN = 3'b000;

    // in_data layout: [7] kind (0=LOAD, 1=CMD), [6:4] opcode/cmd, [3:0] value/arg
    localparam int KIND_BIT = 7;
    localparam int FIELD_HI = 6;
    localparam int FIELD_LO = 4;
    localparam int ARG_HI   = 3;
    localparam int ARG_LO   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN
    } state_e;

    // Opcodes 3 and 7 have no cache meaning and are rejected at issue.
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op != 3'd3) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/op_stream_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface op_stream_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/op_stream_loader_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push is ignored when full
// and pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/op_stream_loader.sv
// Buffers LOAD/CMD words, writes valid ops into the opcode cache one per clock
// and drives timed execute runs; tracks fill count, rejects and cache sync.
module op_stream_loader
    import op_loader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CACHE_DEPTH = 32,
    parameter int RUN_UNIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    op_stream_if.slave  in_bus,
    input  logic        abort,
    input  logic        cache_full,
    output logic        mode,
    output logic [2:0]  op_code,
    output logic [3:0]  op_value,
    output logic        running,
    output logic [5:0]  loaded_count,
    output logic [7:0]  bad_count,
    output logic        drop_full,
    output logic        desync
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          RUN_W     = $clog2(16 * RUN_UNIT);
    localparam logic [5:0]  CACHE_MAX = 6'(CACHE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [7:0]       word;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             push, pop, drains;
    logic [2:0]       fld;
    logic [3:0]       arg;

    state_e           state_q;
    logic             mode_q, running_q, drop_full_q, desync_q;
    logic [2:0]       op_code_q;
    logic [3:0]       op_value_q;
    logic [5:0]       loaded_q;
    logic [7:0]       bad_q;
    logic [RUN_W-1:0] run_cnt_q;

    assign push = in_bus.in_valid && !fifo_full;
    assign pop  = (state_q != ST_RUN) && !fifo_empty;
    // The word being popped was the last one and nothing refills it this edge.
    assign drains = (fifo_cnt == CNT_ONE) && !push;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (in_bus.in_data),
        .pop_i   (pop),
        .data_o  (word),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_bus.in_ready = !fifo_full;
    assign fld = word[FIELD_HI:FIELD_LO];
    assign arg = word[ARG_HI:ARG_LO];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Counter is preloaded with length-1 so mode stays high for exactly the run length.
    function automatic logic [RUN_W-1:0] run_len(input logic [3:0] a);
        return RUN_W'((int'(a) + 1) * RUN_UNIT - 1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            op_code_q   <= OP_NOP;
            op_value_q  <= 4'd0;
            running_q   <= 1'b0;
            loaded_q    <= 6'd0;
            bad_q       <= 8'd0;
            drop_full_q <= 1'b0;
            desync_q    <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            if (cache_full && (loaded_q < CACHE_MAX)) desync_q <= 1'b1;
            mode_q     <= 1'b0;
            op_code_q  <= OP_NOP;
            op_value_q <= 4'd0;
            running_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ISSUE: begin
                    if (!pop) begin
                        state_q <= ST_IDLE;
                    end else if (!word[KIND_BIT]) begin
                        state_q <= drains ? ST_IDLE : ST_ISSUE;
                        if (!is_valid_op(fld)) begin
                            bad_q <= sat_inc(bad_q);
                        end else if (loaded_q == CACHE_MAX) begin
                            drop_full_q <= 1'b1;
                        end else begin
                            op_code_q  <= fld;
                            op_value_q <= arg;
                            loaded_q   <= loaded_q + 6'd1;
                        end
                    end else if ((fld == CMD_RUN) && (loaded_q != 6'd0)) begin
                        state_q   <= ST_RUN;
                        mode_q    <= 1'b1;
                        running_q <= 1'b1;
                        run_cnt_q <= run_len(arg);
                    end else begin
                        state_q <= drains ? ST_IDLE : ST_ISSUE;
                        bad_q   <= sat_inc(bad_q);
                    end
                end
                ST_RUN: begin
                    if (abort || (run_cnt_q == '0)) begin
                        state_q <= fifo_empty ? ST_IDLE : ST_ISSUE;
                    end else begin
                        mode_q    <= 1'b1;
                        running_q <= 1'b1;
                        run_cnt_q <= run_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mode         = mode_q;
    assign op_code      = op_code_q;
    assign op_value     = op_value_q;
    assign running      = running_q;
    assign loaded_count = loaded_q;
    assign bad_count    = bad_q;
    assign drop_full    = drop_full_q;
    assign desync       = desync_q;

endmodule
